// File: rtl/gate_lab_pkg.sv
// rtl/gate_lab_pkg.sv - mode encoding, LED bit positions and gate evaluation for gate_lab
package gate_lab_pkg;

    typedef enum logic [2:0] {
        MODE_NOR  = 3'd0,
        MODE_OR   = 3'd1,
        MODE_AND  = 3'd2,
        MODE_NAND = 3'd3,
        MODE_XOR  = 3'd4,
        MODE_XNOR = 3'd5
    } mode_t;

    localparam logic [2:0] MODE_LAST = 3'd5;

    localparam int LED_RESULT  = 0;
    localparam int LED_MODE_LO = 1;
    localparam int LED_ANY     = 4;
    localparam int LED_BLIP    = 5;

    // Only the low n_in bits of st take part; codes 6 and 7 fall back to NOR.
    function automatic logic gate_eval(input logic [2:0] mode, input logic [3:0] st, input int n_in);
        logic any_p;
        logic all_p;
        logic par_p;
        any_p = 1'b0;
        all_p = 1'b1;
        par_p = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i < n_in) begin
                any_p = any_p | st[i];
                all_p = all_p & st[i];
                par_p = par_p ^ st[i];
            end
        end
        case (mode)
            3'd1:    return any_p;
            3'd2:    return all_p;
            3'd3:    return ~all_p;
            3'd4:    return par_p;
            3'd5:    return ~par_p;
            default: return ~any_p;
        endcase
    endfunction

endpackage

// File: rtl/gate_lab_btn_debounce.sv
// rtl/gate_lab_btn_debounce.sv - two-flop synchroniser and counting debouncer for one active-low button
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 270000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_n,
    output logic st,
    output logic rise
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;
    logic          p_sync;

    assign p_sync = ~sync2;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            cnt   <= '0;
            st    <= 1'b0;
            rise  <= 1'b0;
        end else begin
            sync1 <= raw_n;
            sync2 <= sync1;
            rise  <= 1'b0;
            if (p_sync != st) begin
                // the last differing cycle of the run commits the new level
                if (cnt == CNT_LAST) begin
                    st   <= ~st;
                    cnt  <= '0;
                    rise <= ~st;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/gate_lab.sv
// rtl/gate_lab.sv - debounced push-button logic gate demo with selectable function and LED status
module gate_lab
    import gate_lab_pkg::*;
#(
    parameter int N_IN            = 2,
    parameter int DEBOUNCE_CYCLES = 270000,
    parameter int BLIP_CYCLES     = 13500000,
    parameter int LED_ACTIVE_LOW  = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_IN-1:0] btn_n,
    input  logic            mode_btn_n,
    output logic [5:0]      led
);

    localparam int BW = $clog2(BLIP_CYCLES + 1);
    localparam logic [BW-1:0] BLIP_LOAD = BW'(BLIP_CYCLES);
    localparam logic [5:0] LED_POL = {6{LED_ACTIVE_LOW != 0}};

    logic [N_IN-1:0] st;
    logic [N_IN-1:0] unused_rise;
    logic            unused_mode_st;
    logic            mode_rise;
    mode_t           mode;
    logic [BW-1:0]   blip;
    logic [5:0]      led_lit;

    for (genvar i = 0; i < N_IN; i++) begin : g_btn
        btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
            .clk   (clk),
            .rst   (rst),
            .raw_n (btn_n[i]),
            .st    (st[i]),
            .rise  (unused_rise[i])
        );
    end

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode_btn (
        .clk   (clk),
        .rst   (rst),
        .raw_n (mode_btn_n),
        .st    (unused_mode_st),
        .rise  (mode_rise)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            mode <= MODE_NOR;
            blip <= '0;
        end else if (mode_rise) begin
            mode <= (mode >= MODE_LAST) ? MODE_NOR : mode_t'(mode + 3'd1);
            blip <= BLIP_LOAD;
        end else if (blip != '0) begin
            blip <= blip - 1'b1;
        end
    end

    always_comb begin
        led_lit                      = '0;
        led_lit[LED_RESULT]          = gate_eval(mode, 4'(st), N_IN);
        led_lit[LED_MODE_LO +: 3]    = mode;
        led_lit[LED_ANY]             = |st;
        led_lit[LED_BLIP]            = (blip != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            led <= LED_POL;
        end else begin
            led <= led_lit ^ LED_POL;
        end
    end

endmodule

// File: tb/tb_gate_lab.sv
// tb/tb_gate_lab.sv - directed self-checking bench for gate_lab with short debounce and blip times
module tb_gate_lab;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] btn_n;
    logic       mode_btn_n;
    logic [5:0] led;

    int total = 0;
    int bad   = 0;

    // r for st = 2'b01 in modes NOR, OR, AND, NAND, XOR, XNOR
    logic [5:0] r_st01 = 6'b011010;

    gate_lab #(
        .N_IN            (2),
        .DEBOUNCE_CYCLES (4),
        .BLIP_CYCLES     (8),
        .LED_ACTIVE_LOW  (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_n      (btn_n),
        .mode_btn_n (mode_btn_n),
        .led        (led)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [5:0] got, input logic [5:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%b want=%b", tag, got, want);
        end
    endtask

    function automatic logic [5:0] pins(input logic r, input logic [2:0] m, input logic any, input logic blip);
        return ~{blip, any, m, r};
    endfunction

    initial begin
        int m;
        rst = 1'b1;
        btn_n = 2'b11;
        mode_btn_n = 1'b1;
        step(2);
        check("reset", led, 6'b111111);
        rst = 1'b0;
        step(1);
        check("first_after_reset", led, 6'b111110);
        step(5);
        check("idle_stable", led, 6'b111110);

        // btn0 accepted on the 6th edge, visible on the 7th
        btn_n = 2'b10;
        step(6);
        check("btn0_not_yet", led, 6'b111110);
        step(1);
        check("btn0_accepted", led, 6'b101111);

        // 3-cycle glitch on btn1 is rejected
        btn_n = 2'b00;
        step(3);
        btn_n = 2'b10;
        for (int i = 0; i < 8; i++) begin
            step(1);
            check("glitch_rejected", led, 6'b101111);
        end

        // six long mode presses with btn0 held (st = 01)
        for (int k = 1; k <= 6; k++) begin
            m = k % 6;
            mode_btn_n = 1'b0;
            step(7);
            check("mode_old", led, pins(r_st01[k-1], 3'(k-1), 1'b1, 1'b0));
            step(1);
            check("mode_new_blip", led, pins(r_st01[m], 3'(m), 1'b1, 1'b1));
            step(7);
            check("blip_last", led, pins(r_st01[m], 3'(m), 1'b1, 1'b1));
            step(1);
            check("blip_off", led, pins(r_st01[m], 3'(m), 1'b1, 1'b0));
            mode_btn_n = 1'b1;
            step(10);
            check("release_no_step", led, pins(r_st01[m], 3'(m), 1'b1, 1'b0));
        end

        // two quick presses: second step lands while blip is 1 and reloads it
        mode_btn_n = 1'b0;
        step(4);
        mode_btn_n = 1'b1;
        step(4);
        check("quick_step1", led, pins(r_st01[1], 3'd1, 1'b1, 1'b1));
        mode_btn_n = 1'b0;
        step(4);
        mode_btn_n = 1'b1;
        step(3);
        check("quick_before_step2", led, pins(r_st01[1], 3'd1, 1'b1, 1'b1));
        step(1);
        check("quick_step2", led, pins(r_st01[2], 3'd2, 1'b1, 1'b1));
        step(7);
        check("reload_still_lit", led, pins(r_st01[2], 3'd2, 1'b1, 1'b1));
        step(1);
        check("reload_expired", led, pins(r_st01[2], 3'd2, 1'b1, 1'b0));

        // release btn0, then two more steps to XOR
        btn_n = 2'b11;
        step(10);
        check("mode2_released", led, pins(1'b0, 3'd2, 1'b0, 1'b0));
        for (int k = 0; k < 2; k++) begin
            mode_btn_n = 1'b0;
            step(10);
            mode_btn_n = 1'b1;
            step(10);
        end
        check("xor_idle", led, pins(1'b0, 3'd4, 1'b0, 1'b0));

        // staggered presses in XOR mode
        btn_n = 2'b10;
        step(4);
        btn_n = 2'b00;
        step(3);
        check("xor_one", led, pins(1'b1, 3'd4, 1'b1, 1'b0));
        step(3);
        check("xor_one_hold", led, pins(1'b1, 3'd4, 1'b1, 1'b0));
        step(1);
        check("xor_both", led, pins(1'b0, 3'd4, 1'b1, 1'b0));

        // reset while btn0 is mid-debounce (cnt = 2)
        btn_n = 2'b11;
        step(10);
        btn_n = 2'b10;
        step(4);
        rst = 1'b1;
        step(1);
        check("mid_reset", led, 6'b111111);
        rst = 1'b0;
        step(1);
        check("after_mid_reset", led, 6'b111110);
        step(5);
        check("reaccept_pending", led, 6'b111110);
        step(1);
        check("reaccepted", led, 6'b101111);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gate_lab.md
Name: gate_lab

Overview:
- Parametrised successor to the single two-button NOR demo.
- Takes N_IN raw active-low push-buttons and synchronises and debounces each one.
- Evaluates a selectable logic function, which a dedicated mode button cycles through, and drives the 6 on-board LEDs with the gate result, the mode code and status.
- Top-level board block; the only clocked logic between the pins and the LEDs.

Parameters:
N_IN, 2, number of gate-input buttons (legal 2..4)
DEBOUNCE_CYCLES, 270000, consecutive stable cycles required to accept a level change (10 ms at 27 MHz)
BLIP_CYCLES, 13500000, cycles led[5] stays lit after a mode change (0.5 s)
LED_ACTIVE_LOW, 1, 1: LED lit when pin = 0; 0: lit when pin = 1

Ports:
clk  input  1  system clock
rst  input  1  reset; synchronous, active-high
btn_n  input  N_IN  raw gate-input buttons, asynchronous, active-low (0 = pressed)
mode_btn_n  input  1  raw mode button, asynchronous, active-low
led  output  6  board LEDs, polarity per LED_ACTIVE_LOW, all registered

Behaviour:
- Reset is synchronous and active-high: all state is cleared on the rising clk edge where rst=1.
- Synchroniser: each raw input passes 2 flops, reset value 1 (released). p_sync = ~synced level (1 = pressed).
- Debounce, per channel:
  - st resets to 0 (released); counter cnt resets to 0, width clog2(DEBOUNCE_CYCLES+1).
  - If p_sync != st: cnt increments.
  - If p_sync == st: cnt clears to 0.
  - When cnt == DEBOUNCE_CYCLES-1 and p_sync != st: st flips and cnt clears on that edge. A change is therefore accepted after exactly DEBOUNCE_CYCLES consecutive differing cycles.
  - A glitch shorter than DEBOUNCE_CYCLES never changes st.
  - Per channel, rise = 1 for one cycle when st goes 0->1.
- Mode register, 3 bits:
  - Reset value 0.
  - Encoding: 0 NOR, 1 OR, 2 AND, 3 NAND, 4 XOR, 5 XNOR. Codes 6 and 7 are unreachable; if seen, treat as NOR.
  - On the mode channel's rise: mode <= (mode == 5) ? 0 : mode+1. The update lands on the edge after the rise pulse.
  - Holding the mode button gives exactly one step. A release edge never steps.
- Gate function: r = reduction over st[N_IN-1:0] per mode. NOR = ~|st, OR = |st, AND = &st, NAND = ~&st, XOR = ^st, XNOR = ~^st.
- Blip counter:
  - Resets to 0.
  - Loaded with BLIP_CYCLES on the same edge that mode updates; otherwise decrements while nonzero.
  - A mode change during an active blip reloads the counter to BLIP_CYCLES.
- LED mapping (logical 1 = lit; pin = logical XOR LED_ACTIVE_LOW):
  - led[0] = r
  - led[3:1] = mode
  - led[4] = |st (any gate button pressed)
  - led[5] = (blip != 0)
- LED timing:
  - All LED bits are registered from the current-cycle st, mode and blip. LEDs show the new st or mode one cycle after it changes.
  - Reset value: all LEDs off, i.e. led = {6{LED_ACTIVE_LOW}}.
  - First cycle after rst deasserts: led[0] lit (NOR of all-released = 1), all other LEDs off.
- Simultaneous events: a mode step and a gate-input change on the same edge are both applied. led[0] in the following cycle uses the new mode and the new st together.
- Reset mid-debounce: cnt and st clear. A button still held when reset deasserts is re-accepted after DEBOUNCE_CYCLES.

Decomposition:
- Package gate_lab_pkg:
  - mode enum (MODE_NOR..MODE_XNOR) and MODE_LAST = 5
  - LED index constants: LED_RESULT = 0, LED_MODE_LO = 1, LED_ANY = 4, LED_BLIP = 5
  - function gate_eval(mode, st) returning r
- Sub-module btn_debounce:
  - Contains the synchroniser, debounce counter, st output and rise pulse; parameter DEBOUNCE_CYCLES.
  - Instantiated N_IN+1 times (gate buttons plus mode button).

Test Plan (sim with DEBOUNCE_CYCLES=4, BLIP_CYCLES=8, LED_ACTIVE_LOW=1, N_IN=2):
- Reset release, all buttons released -> led = 6'b111110 (only led[0] lit, mode 0), stable.
- Press btn_n[0] (drive 0) and hold -> st[0]=1 after 2 sync + 4 debounce cycles; next cycle led[0]=1 (off, NOR=0) and led[4]=0 (lit).
- Press btn_n[1] for 3 cycles, then release -> st unchanged, led unchanged throughout.
- Press mode_btn_n 6 times, each held 10 cycles -> led[3:1] steps 1,2,3,4,5,0 (pins inverted). led[5] lit for 8 cycles after each step; a step 4 cycles after the previous one reloads the count to 8.
- Mode = 4 (XOR): press both gate buttons -> led[0] lit after one button is accepted, then off once both are accepted.
- Assert rst for 1 cycle while a button is held mid-debounce (cnt=2) -> led = 6'b111111 on the next edge, mode 0, blip 0. The held button is accepted 2+4 cycles after release of rst.
